// File: rtl/stopwatch_ctrl_if.sv
// Button, tick and control-output bundle between the stopwatch controller and its environment.
// master drives the buttons and tick; slave is the controller itself.
interface stopwatch_ctrl_if;
    logic       tick;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       btn_lap;
    logic       count_en;
    logic       count_clr;
    logic       lap_hold;
    logic [1:0] state;

    modport master (
        output tick,
        output btn_start_stop,
        output btn_clear,
        output btn_lap,
        input  count_en,
        input  count_clr,
        input  lap_hold,
        input  state
    );

    modport slave (
        input  tick,
        input  btn_start_stop,
        input  btn_clear,
        input  btn_lap,
        output count_en,
        output count_clr,
        output lap_hold,
        output state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: synchronises and debounces the buttons, then sequences IDLE/RUN/PAUSE/LAP.
// Define STOPWATCH_LAP_EN to build the lap button path, the LAP state and lap_hold.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W            = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  sw
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;
`ifdef STOPWATCH_LAP_EN
    localparam int BTN_LAP = 2;
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] evt;

    assign btn_raw[BTN_SS]  = sw.btn_start_stop;
    assign btn_raw[BTN_CLR] = sw.btn_clear;
`ifdef STOPWATCH_LAP_EN
    assign btn_raw[BTN_LAP] = sw.btn_lap;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic            sync1_q;
            logic            sync2_q;
            logic            deb_q;
            logic            deb_dly_q;
            logic            evt_q;
            logic [DB_W-1:0] cnt_q;
            logic [DB_W-1:0] cnt_d;
            logic            deb_d;

            // Counter restarts whenever the synchronised input agrees with the debounced level,
            // so only an uninterrupted run of DEBOUNCE_CYCLES differing cycles flips it.
            always_comb begin
                cnt_d = cnt_q + 1'b1;
                deb_d = deb_q;
                if (sync2_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d = '0;
                    deb_d = sync2_q;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                    evt_q     <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    sync1_q   <= btn_raw[gi];
                    sync2_q   <= sync1_q;
                    cnt_q     <= cnt_d;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_q;
                    evt_q     <= deb_q & ~deb_dly_q;
                end
            end

            assign evt[gi] = evt_q;
        end
    endgenerate

    logic evt_ss;
    logic evt_clr;
    logic evt_lap;

    assign evt_ss  = evt[BTN_SS];
    assign evt_clr = evt[BTN_CLR];
`ifdef STOPWATCH_LAP_EN
    assign evt_lap = evt[BTN_LAP];
`else
    assign evt_lap = 1'b0;
`endif

    state_t state_q;
    state_t state_d;
    logic   count_en_q;
    logic   count_en_d;
    logic   count_clr_q;
    logic   count_clr_d;

    // Each state tests its accepted events in clear > start_stop > lap order;
    // whatever loses in the same cycle is simply dropped.
    always_comb begin
        state_d     = state_q;
        count_clr_d = 1'b0;
        count_en_d  = sw.tick && ((state_q == RUN) || (state_q == LAP));
        case (state_q)
            IDLE: begin
                if (evt_clr) begin
                    count_clr_d = 1'b1;
                end else if (evt_ss) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (evt_ss) begin
                    state_d = PAUSE;
                end else if (evt_lap) begin
                    state_d = LAP;
                end
            end
            LAP: begin
                if (evt_ss) begin
                    state_d = PAUSE;
                end else if (evt_lap) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (evt_clr) begin
                    state_d     = IDLE;
                    count_clr_d = 1'b1;
                end else if (evt_ss) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_hold_q <= 1'b0;
        end else begin
            lap_hold_q <= (state_d == LAP);
        end
    end

    assign sw.lap_hold = lap_hold_q;
`else
    assign sw.lap_hold = 1'b0;
`endif

    assign sw.state     = state_q;
    assign sw.count_en  = count_en_q;
    assign sw.count_clr = count_clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4; inputs change and outputs are sampled on negedges.
module tb_stopwatch_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DB_W            (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press and release one button: 0=start_stop 1=clear 2=lap.
    task automatic press_btn(input int which, input int hold);
        case (which)
            0: sw.btn_start_stop = 1'b1;
            1: sw.btn_clear      = 1'b1;
            default: sw.btn_lap  = 1'b1;
        endcase
        step(hold);
        sw.btn_start_stop = 1'b0;
        sw.btn_clear      = 1'b0;
        sw.btn_lap        = 1'b0;
        step(10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL reset_state got=%b exp=00", sw.state); end
        n_cmp++; if (sw.count_en !== 1'b0) begin n_bad++; $display("FAIL reset_count_en got=%b exp=0", sw.count_en); end
        n_cmp++; if (sw.count_clr !== 1'b0) begin n_bad++; $display("FAIL reset_count_clr got=%b exp=0", sw.count_clr); end
        n_cmp++; if (sw.lap_hold !== 1'b0) begin n_bad++; $display("FAIL reset_lap_hold got=%b exp=0", sw.lap_hold); end
        rst_n = 1'b1;
        step(3);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL post_reset_state got=%b exp=00", sw.state); end
        $display("test_reset done");
    endtask

    task automatic test_start;
        sw.btn_start_stop = 1'b1;
        step(7);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL start_before_edge got=%b exp=00", sw.state); end
        step(1);
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL start_at_edge got=%b exp=01", sw.state); end
        step(12);
        sw.btn_start_stop = 1'b0;
        step(10);
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL start_after_release got=%b exp=01", sw.state); end
        for (int i = 0; i < 3; i++) begin
            sw.tick = 1'b1;
            step(1);
            sw.tick = 1'b0;
            n_cmp++; if (sw.count_en !== 1'b1) begin n_bad++; $display("FAIL run_tick%0d count_en got=%b exp=1", i, sw.count_en); end
            step(1);
            n_cmp++; if (sw.count_en !== 1'b0) begin n_bad++; $display("FAIL run_notick%0d count_en got=%b exp=0", i, sw.count_en); end
        end
        $display("test_start done");
    endtask

    task automatic test_glitch;
        sw.btn_start_stop = 1'b1;
        step(3);
        sw.btn_start_stop = 1'b0;
        step(12);
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL glitch_state got=%b exp=01", sw.state); end
        $display("test_glitch done");
    endtask

    task automatic test_stop_tick_edge;
        sw.btn_start_stop = 1'b1;
        step(7);
        sw.tick = 1'b1;
        step(1);
        sw.tick = 1'b0;
        n_cmp++; if (sw.state !== 2'b10) begin n_bad++; $display("FAIL stop_state got=%b exp=10", sw.state); end
        n_cmp++; if (sw.count_en !== 1'b1) begin n_bad++; $display("FAIL stop_edge_count_en got=%b exp=1", sw.count_en); end
        step(1);
        sw.tick = 1'b1;
        step(1);
        sw.tick = 1'b0;
        n_cmp++; if (sw.count_en !== 1'b0) begin n_bad++; $display("FAIL pause_tick_count_en got=%b exp=0", sw.count_en); end
        step(1);
        sw.btn_start_stop = 1'b0;
        step(10);
        n_cmp++; if (sw.state !== 2'b10) begin n_bad++; $display("FAIL stop_after_release got=%b exp=10", sw.state); end
        $display("test_stop_tick_edge done");
    endtask

    task automatic test_resume_tick_edge;
        sw.btn_start_stop = 1'b1;
        step(7);
        sw.tick = 1'b1;
        step(1);
        sw.tick = 1'b0;
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL resume_state got=%b exp=01", sw.state); end
        n_cmp++; if (sw.count_en !== 1'b0) begin n_bad++; $display("FAIL resume_edge_count_en got=%b exp=0", sw.count_en); end
        sw.tick = 1'b1;
        step(1);
        sw.tick = 1'b0;
        n_cmp++; if (sw.count_en !== 1'b1) begin n_bad++; $display("FAIL resume_tick_count_en got=%b exp=1", sw.count_en); end
        step(1);
        sw.btn_start_stop = 1'b0;
        step(10);
        $display("test_resume_tick_edge done");
    endtask

    task automatic test_clear;
        logic seen;
        seen = 1'b0;
        sw.btn_clear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sw.count_clr === 1'b1) seen = 1'b1;
        end
        sw.btn_clear = 1'b0;
        step(10);
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL clear_in_run pulse_seen=%b exp=0", seen); end
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL clear_in_run state got=%b exp=01", sw.state); end
        press_btn(0, 10);
        n_cmp++; if (sw.state !== 2'b10) begin n_bad++; $display("FAIL clear_setup_pause got=%b exp=10", sw.state); end
        sw.btn_clear = 1'b1;
        step(7);
        n_cmp++; if (sw.count_clr !== 1'b0) begin n_bad++; $display("FAIL clear_pause_early count_clr got=%b exp=0", sw.count_clr); end
        step(1);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL clear_pause state got=%b exp=00", sw.state); end
        n_cmp++; if (sw.count_clr !== 1'b1) begin n_bad++; $display("FAIL clear_pause count_clr got=%b exp=1", sw.count_clr); end
        step(1);
        n_cmp++; if (sw.count_clr !== 1'b0) begin n_bad++; $display("FAIL clear_pause_width count_clr got=%b exp=0", sw.count_clr); end
        step(8);
        sw.btn_clear = 1'b0;
        step(10);
        sw.btn_clear = 1'b1;
        step(8);
        n_cmp++; if (sw.count_clr !== 1'b1) begin n_bad++; $display("FAIL clear_idle count_clr got=%b exp=1", sw.count_clr); end
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL clear_idle state got=%b exp=00", sw.state); end
        step(1);
        n_cmp++; if (sw.count_clr !== 1'b0) begin n_bad++; $display("FAIL clear_idle_width count_clr got=%b exp=0", sw.count_clr); end
        step(1);
        sw.btn_clear = 1'b0;
        step(10);
        $display("test_clear done");
    endtask

    task automatic test_lap;
`ifdef STOPWATCH_LAP_EN
        sw.btn_lap = 1'b1;
        step(8);
        n_cmp++; if (sw.state !== 2'b11) begin n_bad++; $display("FAIL lap_enter state got=%b exp=11", sw.state); end
        n_cmp++; if (sw.lap_hold !== 1'b1) begin n_bad++; $display("FAIL lap_enter lap_hold got=%b exp=1", sw.lap_hold); end
        sw.tick = 1'b1;
        step(1);
        sw.tick = 1'b0;
        n_cmp++; if (sw.count_en !== 1'b1) begin n_bad++; $display("FAIL lap_tick count_en got=%b exp=1", sw.count_en); end
        step(1);
        sw.btn_lap = 1'b0;
        step(10);
        n_cmp++; if (sw.lap_hold !== 1'b1) begin n_bad++; $display("FAIL lap_hold_steady got=%b exp=1", sw.lap_hold); end
        sw.btn_lap = 1'b1;
        step(8);
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL lap_exit state got=%b exp=01", sw.state); end
        n_cmp++; if (sw.lap_hold !== 1'b0) begin n_bad++; $display("FAIL lap_exit lap_hold got=%b exp=0", sw.lap_hold); end
        step(2);
        sw.btn_lap = 1'b0;
        step(10);
`else
        logic seen;
        seen = 1'b0;
        sw.btn_lap = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sw.lap_hold !== 1'b0 || sw.state !== 2'b01) seen = 1'b1;
        end
        sw.btn_lap = 1'b0;
        step(10);
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL lap_disabled change_seen=%b exp=0", seen); end
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL lap_disabled state got=%b exp=01", sw.state); end
`endif
        $display("test_lap done");
    endtask

    task automatic test_simultaneous;
        press_btn(0, 10);
        n_cmp++; if (sw.state !== 2'b10) begin n_bad++; $display("FAIL simul_setup_pause got=%b exp=10", sw.state); end
        sw.btn_clear      = 1'b1;
        sw.btn_start_stop = 1'b1;
        step(8);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL simul_state got=%b exp=00", sw.state); end
        n_cmp++; if (sw.count_clr !== 1'b1) begin n_bad++; $display("FAIL simul_count_clr got=%b exp=1", sw.count_clr); end
        step(1);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL simul_ss_dropped got=%b exp=00", sw.state); end
        step(1);
        sw.btn_clear      = 1'b0;
        sw.btn_start_stop = 1'b0;
        step(10);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL simul_after_release got=%b exp=00", sw.state); end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid;
        press_btn(0, 10);
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL rmid_setup_run got=%b exp=01", sw.state); end
`ifdef STOPWATCH_LAP_EN
        press_btn(2, 10);
        n_cmp++; if (sw.state !== 2'b11) begin n_bad++; $display("FAIL rmid_setup_lap got=%b exp=11", sw.state); end
`endif
        sw.btn_start_stop = 1'b1;
        step(2);
        sw.tick = 1'b1;
        step(1);
        sw.tick = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL rmid_state got=%b exp=00", sw.state); end
        n_cmp++; if (sw.count_en !== 1'b0) begin n_bad++; $display("FAIL rmid_count_en got=%b exp=0", sw.count_en); end
        n_cmp++; if (sw.count_clr !== 1'b0) begin n_bad++; $display("FAIL rmid_count_clr got=%b exp=0", sw.count_clr); end
        n_cmp++; if (sw.lap_hold !== 1'b0) begin n_bad++; $display("FAIL rmid_lap_hold got=%b exp=0", sw.lap_hold); end
        @(negedge clk);
        rst_n = 1'b1;
        step(7);
        n_cmp++; if (sw.state !== 2'b00) begin n_bad++; $display("FAIL rmid_before_edge got=%b exp=00", sw.state); end
        step(1);
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL rmid_restart got=%b exp=01", sw.state); end
        step(2);
        sw.btn_start_stop = 1'b0;
        step(12);
        n_cmp++; if (sw.state !== 2'b01) begin n_bad++; $display("FAIL rmid_single_event got=%b exp=01", sw.state); end
        $display("test_reset_mid done");
    endtask

    initial begin
        n_cmp             = 0;
        n_bad             = 0;
        rst_n             = 1'b0;
        sw.tick           = 1'b0;
        sw.btn_start_stop = 1'b0;
        sw.btn_clear      = 1'b0;
        sw.btn_lap        = 1'b0;
        test_reset();
        test_start();
        test_glitch();
        test_stop_tick_edge();
        test_resume_tick_edge();
        test_clear();
        press_btn(0, 10);
        test_lap();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
